// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit with fixed-latency HI/LO writeback
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          md_go, finish, idle_start;
    logic [31:0]   abs_a, abs_b, quo, rem;
    logic [63:0]   res;
    logic          res_wr;
    logic [31:0]   pend_hi, pend_lo;
    logic          pend_wr;

    assign idle_start = (state == IDLE) && start;
    assign md_go      = idle_start && (op >= OP_MULT) && (op <= OP_DIVU);

    // Result datapath: signed divide works on magnitudes and fixes signs afterwards
    always_comb begin
        abs_a  = (op == OP_DIV && A[31]) ? -A : A;
        abs_b  = (op == OP_DIV && B[31]) ? -B : B;
        quo    = (abs_b == '0) ? '0 : abs_a / abs_b;
        rem    = (abs_b == '0) ? '0 : abs_a % abs_b;
        res    = (op == OP_MULT)  ? {{32{A[31]}}, A} * {{32{B[31]}}, B} :
                 (op == OP_MULTU) ? {32'b0, A} * {32'b0, B} :
                 {(op == OP_DIV && A[31]) ? -rem : rem,
                  (op == OP_DIV && (A[31] ^ B[31])) ? -quo : quo};
        res_wr = !((op == OP_DIV || op == OP_DIVU) && B == '0);
    end

    // State and latency counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: load latency on accept, count down, finish when the last busy cycle ends
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        finish  = 1'b0;
        busy    = (state == BUSY);
        if (md_go) begin
            state_n = BUSY;
            cnt_n   = (op == OP_MULT || op == OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (state == BUSY) begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                finish  = 1'b1;
                state_n = IDLE;
            end
        end
    end

    // HI/LO and pending result; divide by zero leaves HI/LO untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            if (md_go) begin
                pend_hi <= res[63:32];
                pend_lo <= res[31:0];
                pend_wr <= res_wr;
            end
            if (finish && pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
            if (idle_start && op == OP_MTHI) HI <= A;
            if (idle_start && op == OP_MTLO) LO <= A;
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized and directed check of e_mdu against an arithmetic reference model
module tb_e_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, reset, start, busy;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic [31:0] exp_hi, exp_lo;
    int          errors, checks;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(a), .B(b), .busy(busy), .HI(hi), .LO(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      p, q, r;
        logic [63:0] u;
        case (o)
            3'd1: begin
                p = longint'($signed(x)) * longint'($signed(y));
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd2: begin
                u = 64'(x) * 64'(y);
                exp_hi = u[63:32];
                exp_lo = u[31:0];
            end
            3'd3: if (y != 0) begin
                q = longint'($signed(x)) / longint'($signed(y));
                r = longint'($signed(x)) % longint'($signed(y));
                exp_lo = q[31:0];
                exp_hi = r[31:0];
            end
            3'd4: if (y != 0) begin
                exp_lo = x / y;
                exp_hi = x % y;
            end
            3'd5: exp_hi = x;
            3'd6: exp_lo = x;
            default: ;
        endcase
    endfunction

    // mode 0: quiet while busy; 1: MTLO then DIV attempted on busy cycles 2 and 3; 2: random junk
    task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int mode, input string tag);
        logic [31:0] oh, ol;
        int len, n;
        oh = exp_hi;
        ol = exp_lo;
        n = (o <= 3'd2) ? MC : DC;
        start = 1'b1; op = o; a = x; b = y;
        tick;
        start = 1'b0; op = 3'd0;
        chk({tag, "_nobypass_hi"}, hi, oh);
        chk({tag, "_nobypass_lo"}, lo, ol);
        len = 0;
        while (busy && len < 40) begin
            if (mode == 1 && len == 1) begin
                start = 1'b1; op = 3'd6; a = 32'hDEADBEEF;
            end else if (mode == 1 && len == 2) begin
                start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
            end else if (mode == 2) begin
                start = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            tick;
            len++;
        end
        start = 1'b0; op = 3'd0;
        model(o, x, y);
        chk({tag, "_busy_len"}, 32'(len), 32'(n));
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    task automatic run_imm(input logic [2:0] o, input logic [31:0] x, input logic s, input string tag);
        start = s; op = o; a = x; b = $urandom;
        tick;
        start = 1'b0; op = 3'd0;
        if (s) model(o, x, 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        exp_hi = '0; exp_lo = '0;
        tick; tick;
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        run_md(3'd1, 32'hFFFFFFFE, 32'd3, 0, "mult");
        chk("mult_hi_const", hi, 32'hFFFFFFFF);
        chk("mult_lo_const", lo, 32'hFFFFFFFA);
        run_md(3'd2, 32'hFFFFFFFE, 32'd3, 0, "multu");
        chk("multu_hi_const", hi, 32'h00000002);
        run_md(3'd3, 32'hFFFFFFF9, 32'd2, 0, "div");
        chk("div_lo_const", lo, 32'hFFFFFFFD);
        chk("div_hi_const", hi, 32'hFFFFFFFF);

        run_imm(3'd5, 32'h12345678, 1'b1, "mthi");
        run_imm(3'd6, 32'h9ABCDEF0, 1'b1, "mtlo");
        run_md(3'd4, 32'd7, 32'd0, 0, "divu_zero");
        chk("divz_hi_const", hi, 32'h12345678);
        chk("divz_lo_const", lo, 32'h9ABCDEF0);

        run_md(3'd1, 32'd1234, 32'hFFFFFF00, 1, "ignored");

        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        tick;
        start = 1'b0; op = 3'd0;
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        repeat (12) tick;
        chk("midrst_late_busy", 32'(busy), 32'd0);
        chk("midrst_late_hi", hi, 32'd0);
        chk("midrst_late_lo", lo, 32'd0);

        reset = 1'b1; start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
        tick;
        reset = 1'b0; start = 1'b0; op = 3'd0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        tick;
        chk("rst_start_busy2", 32'(busy), 32'd0);

        run_md(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
        chk("div_ovf_lo_const", lo, 32'h80000000);
        chk("div_ovf_hi_const", hi, 32'h00000000);
        run_md(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "b2b_multu");
        chk("b2b_hi_const", hi, 32'hFFFFFFFE);
        chk("b2b_lo_const", lo, 32'h00000001);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom);
            x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            y = ($urandom_range(0, 6) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if (o >= 3'd1 && o <= 3'd4) run_md(o, x, y, 2 * $urandom_range(0, 1), "rnd_md");
            else run_imm(o, x, 1'($urandom), "rnd_imm");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
